// File: rtl/mem_stage_lsu_if.sv
// Data-memory req/gnt/rvalid port bundle between the MEM-stage LSU and memory.
// The LSU takes the master side and the memory model takes the slave side.
interface mem_stage_lsu_if;
   logic        dmem_req_o;
   logic        dmem_we_o;
   logic [31:0] dmem_addr_o;
   logic [31:0] dmem_wdata_o;
   logic [3:0]  dmem_wstrb_o;
   logic        dmem_gnt_i;
   logic        dmem_rvalid_i;
   logic [31:0] dmem_rdata_i;

   modport master (
      output dmem_req_o, dmem_we_o, dmem_addr_o,
      output dmem_wdata_o, dmem_wstrb_o,
      input  dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
   );

   modport slave (
      input  dmem_req_o, dmem_we_o, dmem_addr_o,
      input  dmem_wdata_o, dmem_wstrb_o,
      output dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
   );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: issues data-memory accesses, aligns load data,
// builds store strobes and stalls the pipeline until the access completes.
module mem_stage_lsu #(
   parameter int unsigned TIMEOUT_CYC = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] alu_result_in,
   input  logic [31:0] rs2_data_in,
   input  logic [4:0]  rd_in,
   input  logic        reg_write_in,
   input  logic        mem_to_reg_in,
   input  logic        mem_write_in,
   input  logic [2:0]  funct3_in,
   mem_stage_lsu_if.master dmem,
   output logic [31:0] alu_result_out,
   output logic [31:0] mem_data_out,
   output logic [4:0]  rd_out,
   output logic        reg_write_out,
   output logic        mem_to_reg_out,
   output logic        stall_o,
   output logic        misalign_o,
   output logic        bus_err_o
);

   localparam int unsigned CW =
      (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic        is_mem, is_byte, is_half, is_word;
   logic        misal, req, stall, done, tmo, wd_hit;
   logic [1:0]  lane;
   logic [3:0]  strb;
   logic [31:0] wdata, ld;
   logic [7:0]  ld_b;
   logic [15:0] ld_h;
   logic        sx;

   assign lane    = alu_result_in[1:0];
   assign is_mem  = mem_to_reg_in | mem_write_in;
   assign is_byte = funct3_in[1:0] == 2'b00;
   assign is_half = funct3_in[1:0] == 2'b01;
   assign is_word = funct3_in[1];
   assign misal   = is_mem &
                    ((is_half & lane[0]) | (is_word & (|lane)));
   assign sx      = ~funct3_in[2];
   assign ld_b    = dmem.dmem_rdata_i[{lane, 3'b000} +: 8];
   assign ld_h    = dmem.dmem_rdata_i[{lane[1], 4'b0000} +: 16];

   always_comb begin
      strb  = 4'b0000;
      wdata = 32'h0;
      ld    = 32'h0;
      unique case (1'b1)
         is_word: begin
            strb  = 4'b1111;
            wdata = rs2_data_in;
            ld    = dmem.dmem_rdata_i;
         end
         is_half: begin
            strb  = lane[1] ? 4'b1100 : 4'b0011;
            wdata = {2{rs2_data_in[15:0]}};
            ld    = {{16{sx & ld_h[15]}}, ld_h};
         end
         is_byte: begin
            strb  = 4'b0001 << lane;
            wdata = {4{rs2_data_in[7:0]}};
            ld    = {{24{sx & ld_b[7]}}, ld_b};
         end
      endcase
   end

   // Watchdog fires on the last permitted REQ/WAIT cycle.
   assign wd_hit = (TIMEOUT_CYC != 0) && (cnt_q == CNT_LAST);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      req     = 1'b0;
      stall   = 1'b0;
      done    = 1'b0;
      tmo     = 1'b0;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (is_mem & ~misal) begin
               req     = 1'b1;
               stall   = 1'b1;
               state_d = dmem.dmem_gnt_i ? WAIT : REQ;
            end
         end
         REQ: begin
            cnt_d = cnt_q + CW'(1);
            if (wd_hit) begin
               tmo     = 1'b1;
               state_d = IDLE;
            end else begin
               req   = 1'b1;
               stall = 1'b1;
               if (dmem.dmem_gnt_i) state_d = WAIT;
            end
         end
         WAIT: begin
            cnt_d = cnt_q + CW'(1);
            if (dmem.dmem_rvalid_i) begin
               done    = 1'b1;
               state_d = IDLE;
            end else if (wd_hit) begin
               tmo     = 1'b1;
               state_d = IDLE;
            end else begin
               stall = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign dmem.dmem_req_o   = ~rst & req;
   assign dmem.dmem_we_o    = mem_write_in;
   assign dmem.dmem_addr_o  = {alu_result_in[31:2], 2'b00};
   assign dmem.dmem_wdata_o = wdata;
   assign dmem.dmem_wstrb_o = mem_write_in ? strb : 4'b0000;

   assign alu_result_out = alu_result_in;
   assign rd_out         = rd_in;
   assign mem_data_out   = (mem_to_reg_in & done) ? ld : 32'h0;
   assign reg_write_out  = ~rst & reg_write_in &
                           (is_mem ? done : 1'b1);
   assign mem_to_reg_out = ~rst & mem_to_reg_in;
   assign stall_o        = ~rst & stall;
   assign misalign_o     = ~rst & (state_q == IDLE) & misal;
   assign bus_err_o      = ~rst & tmo;

endmodule
